// File: rtl/uart_tx_engine.sv
// UART transmit engine: valid/ready write port into a small holding FIFO, serialised
// LSB-first as start / 5..9 data / optional parity / 1..2 stop bits, paced by baud_tick.
module uart_tx_engine #(
    parameter int DATA_W     = 9,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          baud_tick,
    input  logic [3:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic [DATA_W-1:0]             tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ---------------------------------------------------------------- FIFO
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              push, pop, fifo_nempty;

    assign tx_ready    = rst_n && (level_q != LVL_W'(FIFO_DEPTH));
    assign push        = tx_valid && tx_ready;
    assign fifo_nempty = (level_q != '0);
    assign fifo_level  = level_q;

    // NOTE: storage is deliberately not reset; level and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ---------------------------------------------------------------- framer
    logic [2:0]        state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [3:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic [3:0]        nbits_q, nbits_d;
    logic [1:0]        parity_q, parity_d;
    logic              stop2_q, stop2_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic [3:0]        nbits_cfg;
    logic              bit_end, par_en;

    always_comb begin
        nbits_cfg = cfg_data_bits;
        if (cfg_data_bits < 4'd5) begin
            nbits_cfg = 4'd5;
        end else if (cfg_data_bits > 4'(DATA_W)) begin
            nbits_cfg = 4'(DATA_W);
        end
    end

    assign bit_end = baud_tick && (tick_q == TICK_LAST);
    assign par_en  = (parity_q == 2'b01) || (parity_q == 2'b10);

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        nbits_d  = nbits_q;
        parity_d = parity_q;
        stop2_d  = stop2_q;
        done_d   = 1'b0;
        pop      = 1'b0;

        if (baud_tick && (state_q != S_IDLE)) begin
            tick_d = tick_q + TICK_W'(1);
        end

        case (state_q)
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    tick_d  = '0;
                    if (bit_q == nbits_q - 4'd1) begin
                        bit_d   = '0;
                        state_d = par_en ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    tick_d = '0;
                    if (stop2_q && (bit_q == 4'd0)) begin
                        bit_d = 4'd1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase

        // A frame is loaded from IDLE or straight out of the final stop bit, so
        // back-to-back frames have no idle gap.
        if (fifo_nempty && ((state_q == S_IDLE) || (done_d == 1'b1))) begin
            pop      = 1'b1;
            state_d  = S_START;
            tick_d   = '0;
            bit_d    = '0;
            shift_d  = mem_q[rd_ptr_q];
            par_d    = 1'b0;
            nbits_d  = nbits_cfg;
            parity_d = cfg_parity;
            stop2_d  = cfg_stop2;
        end

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d ^ (parity_q == 2'b10);
            default:  tx_d = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            nbits_q  <= 4'd5;
            parity_q <= 2'b00;
            stop2_q  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            nbits_q  <= nbits_d;
            parity_q <= parity_d;
            stop2_q  <= stop2_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: writes push whole expected line frames into a
// queue; an independent line monitor decodes tx bit by bit and compares.
module tb_uart_tx_engine;

    localparam int OVS   = 16;
    localparam int LIMIT = 20000;

    typedef struct {
        logic [15:0] bits;   // line level of each bit period, in time order
        int          n;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud_tick;
    logic [3:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic [8:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [2:0] fifo_level;

    frame_t exp_q[$];
    int     n_cmp = 0;
    int     n_fail = 0;
    int     done_cnt = 0;
    int     frames_seen = 0;
    int     tick_mode = 0;

    uart_tx_engine #(.DATA_W(9), .OVERSAMPLE(OVS), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_tick     (baud_tick),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .tx            (tx),
        .busy          (busy),
        .frame_done    (frame_done),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input logic ok, input string name, input int act, input int req);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference: the line image of a frame, straight from the framing rules.
    function automatic frame_t model(input logic [8:0] d, input logic [3:0] nb,
                                     input logic [1:0] par, input logic s2);
        frame_t f;
        int     n;
        int     k;
        int     ones;
        n = (nb < 5) ? 5 : ((nb > 9) ? 9 : int'(nb));
        f.bits = '1;
        f.bits[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < n; i++) begin
            f.bits[1 + i] = d[i];
            ones += int'(d[i]);
        end
        k = 1 + n;
        if (par == 2'b01 || par == 2'b10) begin
            f.bits[k] = ((ones % 2) == 1) ^ (par == 2'b10);
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        if (s2) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n = k;
        return f;
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_cfg(input logic [3:0] nb, input logic [1:0] par, input logic s2);
        cfg_data_bits = nb;
        cfg_parity    = par;
        cfg_stop2     = s2;
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send(input logic [8:0] d);
        int w = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && w < LIMIT) begin
            cycles(1);
            w++;
        end
        check(w < LIMIT, "ready_wait", w, LIMIT);
        if (w < LIMIT) begin
            @(posedge clk);
            exp_q.push_back(model(d, cfg_data_bits, cfg_parity, cfg_stop2));
            #1;
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        while ((busy !== 1'b0 || fifo_level !== 3'd0 || exp_q.size() != 0) && w < LIMIT) begin
            cycles(1);
            w++;
        end
        check(w < LIMIT, name, w, LIMIT);
        cycles(3);
    endtask

    initial begin : baud_gen
        baud_tick = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            baud_tick = (tick_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_done === 1'b1) done_cnt++;
    end

    // Line monitor: a bit lasts until OVS baud_ticks have been applied after it began.
    initial begin : monitor
        frame_t     e;
        logic       carry, aborted, bad, need, first;
        logic [2:0] act, want, smp;
        logic [2:0] lvl_last;
        int         ticks;
        carry = 1'b0;
        lvl_last = '0;
        forever begin
            if (!carry) @(negedge clk);
            carry = 1'b0;
            if (rst_n === 1'b1 && tx === 1'b0) begin
                check(exp_q.size() != 0, "frame_expected", exp_q.size(), 1);
                if (exp_q.size() == 0) begin
                    for (int k = 0; k < 300 && tx === 1'b0; k++) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    aborted = 1'b0;
                    need = 1'b0;
                    first = 1'b1;
                    for (int b = 0; b < e.n && !aborted; b++) begin
                        ticks = 0;
                        bad = 1'b0;
                        act = '0;
                        want = {1'b0, 1'b1, e.bits[b]};
                        while (ticks < OVS && !aborted) begin
                            if (need) @(negedge clk);
                            need = 1'b1;
                            if (rst_n !== 1'b1) begin
                                aborted = 1'b1;
                            end else begin
                                smp = {frame_done, busy, tx};
                                if (!bad && (first ? (smp[1:0] !== want[1:0]) : (smp !== want))) begin
                                    bad = 1'b1;
                                    act = smp;
                                end
                                first = 1'b0;
                                lvl_last = fifo_level;
                                if (baud_tick === 1'b1) ticks++;
                            end
                        end
                        if (!aborted) begin
                            check(!bad, $sformatf("frame%0d_bit%0d(done,busy,tx)", frames_seen, b),
                                  int'(act), int'(want));
                        end
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (rst_n === 1'b1) begin
                            check(frame_done === 1'b1, "frame_done_pulse", int'(frame_done), 1);
                            check({busy, tx} === ((lvl_last != 0) ? 2'b10 : 2'b01),
                                  "post_frame_busy_tx", int'({busy, tx}),
                                  (lvl_last != 0) ? 2 : 1);
                            frames_seen++;
                            carry = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int d0;
        int f0;
        int w;
        int nw;
        rst_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 9'h155;
        set_cfg(4'd8, 2'b00, 1'b0);

        // Reset with a word offered: nothing may be accepted.
        cycles(3);
        check(tx === 1'b1, "rst_tx", int'(tx), 1);
        check(busy === 1'b0, "rst_busy", int'(busy), 0);
        check(fifo_level === 3'd0, "rst_level", int'(fifo_level), 0);
        check(tx_ready === 1'b0, "rst_ready", int'(tx_ready), 0);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        cycles(1);
        check(tx_ready === 1'b1, "post_rst_ready", int'(tx_ready), 1);
        cycles(3);
        check(fifo_level === 3'd0, "post_rst_no_capture", int'(fifo_level), 0);
        check(tx === 1'b1, "post_rst_tx", int'(tx), 1);

        // 8N1 0xA5 with handshake-to-start latency.
        d0 = done_cnt;
        send(9'h0A5);
        check(fifo_level === 3'd1, "hs_level", int'(fifo_level), 1);
        check(tx === 1'b1, "hs_tx_idle", int'(tx), 1);
        cycles(1);
        check(tx === 1'b0, "start_tx", int'(tx), 0);
        check(busy === 1'b1, "start_busy", int'(busy), 1);
        check(fifo_level === 3'd0, "start_popped", int'(fifo_level), 0);
        wait_idle("8n1_idle");
        check(done_cnt - d0 == 1, "8n1_done_count", done_cnt - d0, 1);

        // 8E1 and 8O1.
        for (int p = 1; p <= 2; p++) begin
            set_cfg(4'd8, 2'(p), 1'b0);
            d0 = done_cnt;
            send(9'h0A5);
            wait_idle("8p1_idle");
            check(done_cnt - d0 == 1, "8p1_done_count", done_cnt - d0, 1);
        end

        // 7O2 with upper bits ignored; config changes mid-frame must not matter.
        set_cfg(4'd7, 2'b10, 1'b1);
        d0 = done_cnt;
        send(9'h1D5);
        cycles(40);
        set_cfg(4'd5, 2'b01, 1'b0);
        wait_idle("7o2_idle");
        check(done_cnt - d0 == 1, "7o2_done_count", done_cnt - d0, 1);

        // FIFO full, source stall, back-to-back frames.
        set_cfg(4'd8, 2'b00, 1'b0);
        d0 = done_cnt;
        for (int i = 0; i < 5; i++) send(9'($urandom));
        check(fifo_level === 3'd4, "full_level", int'(fifo_level), 4);
        check(tx_ready === 1'b0, "full_ready", int'(tx_ready), 0);
        cycles(10);
        check(fifo_level === 3'd4, "stall_level", int'(fifo_level), 4);
        send(9'($urandom));
        wait_idle("full_idle");
        check(done_cnt - d0 == 6, "full_done_count", done_cnt - d0, 6);

        // Reset during data bit 3, with a second word queued.
        send(9'h000);
        send(9'h000);
        cycles(70);
        check(tx === 1'b0, "mid_data_tx", int'(tx), 0);
        d0 = done_cnt;
        rst_n = 1'b0;
        cycles(1);
        check(tx === 1'b1, "mid_rst_tx", int'(tx), 1);
        check(fifo_level === 3'd0, "mid_rst_level", int'(fifo_level), 0);
        check(busy === 1'b0, "mid_rst_busy", int'(busy), 0);
        check(tx_ready === 1'b0, "mid_rst_ready", int'(tx_ready), 0);
        exp_q.delete();
        cycles(2);
        rst_n = 1'b1;
        cycles(60);
        check(tx === 1'b1, "after_rst_tx", int'(tx), 1);
        check(busy === 1'b0, "after_rst_busy", int'(busy), 0);
        check(done_cnt == d0, "after_rst_no_done", done_cnt - d0, 0);

        // Data-bit clamps.
        set_cfg(4'd2, 2'b00, 1'b0);
        send(9'($urandom));
        wait_idle("clamp_lo_idle");
        set_cfg(4'd15, 2'b01, 1'b1);
        send(9'($urandom));
        wait_idle("clamp_hi_idle");

        // Randomised traffic with sparse baud ticks.
        tick_mode = 1;
        d0 = done_cnt;
        f0 = frames_seen;
        nw = 0;
        for (int g = 0; g < 6; g++) begin
            w = 0;
            while (fifo_level !== 3'd0 && w < LIMIT) begin
                cycles(1);
                w++;
            end
            check(w < LIMIT, "rand_drain_wait", w, LIMIT);
            set_cfg(4'($urandom), 2'($urandom), 1'($urandom));
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                send(9'($urandom));
                nw++;
                cycles($urandom_range(0, 3));
            end
        end
        wait_idle("rand_idle");
        check(done_cnt - d0 == nw, "rand_done_count", done_cnt - d0, nw);
        check(frames_seen - f0 == nw, "rand_frames_seen", frames_seen - f0, nw);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmit engine: accepts words over a valid/ready handshake into a small holding FIFO and serialises them LSB-first. Each frame is start bit, 5..9 data bits, optional even/odd parity and 1 or 2 stop bits; all three frame options are selected at run time. Bit timing is derived from an external oversampling tick. The block sits between the bus-side register interface and the TX pin. It supersedes the fixed-format transmit controller by adding runtime frame format, buffering and back-to-back frames.

## Interface
- DATA_W, 9: maximum data bits per frame; legal range 5..9.
- OVERSAMPLE, 16: baud_tick pulses per bit; minimum 2.
- FIFO_DEPTH, 4: holding FIFO entries; power of two, minimum 2.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- baud_tick  in  1  one-clk pulse per oversample period.
- cfg_data_bits  in  4  data bits per frame; <5 clamps to 5, >DATA_W clamps to DATA_W.
- cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  in  1  1 = two stop bits.
- tx_data  in  DATA_W  word to send; only the low cfg_data_bits bits are transmitted.
- tx_valid  in  1  word offered.
- tx_ready  out  1  = FIFO not full; forced 0 while rst_n low.
- tx  out  1  serial line; idle high.
- busy  out  1  frame in progress (START..STOP).
- frame_done  out  1  one-clk pulse at the end of every frame.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries held.

## Operation
- Write: tx_valid && tx_ready stores tx_data; FIFO pops only from the registered non-empty state, with no fall-through.
- Simultaneous write and pop when not full: both occur; level is unchanged.
- Writes are impossible when full (tx_ready=0); data is held by the source.
- Frame load: pop the head into the shift register, latch cfg_data_bits (clamped), cfg_parity and cfg_stop2. Config changes mid-frame do not affect the current frame.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If the FIFO is non-empty, load and go to START.
  - START: tx=0. At bit end, go to DATA.
  - DATA: tx = shift register LSB; shift right at each bit end. After the last data bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: tx = XOR of the transmitted data bits for even, inverted for odd. At bit end, go to STOP.
  - STOP: tx=1 for 1 or 2 bit periods. At the final bit end, pulse frame_done. If the FIFO is non-empty, load and go directly to START (no idle gap); else go to IDLE.
- Bit timer:
  - The tick counter (0..OVERSAMPLE-1) clears on every state entry.
  - It increments on baud_tick.
  - Bit end is a baud_tick with counter==OVERSAMPLE-1.
  - The bit counter counts data bits and stop bits.
- Reset (any cycle, including mid-frame): FIFO emptied, FSM to IDLE, counters 0, shift register 0. Outputs: tx=1, busy=0, frame_done=0, fifo_level=0, tx_ready=0. The partial frame is abandoned and the line returns high at the next edge.

## Timing
- Handshake at edge N with FSM in IDLE and FIFO empty:
  - edge N+1: fifo_level=1.
  - edge N+2: pop, tx=0, busy=1.
- Each bit lasts exactly OVERSAMPLE baud_ticks after state entry. With baud_tick tied high, a bit is OVERSAMPLE clks.
- Frame length in bits: 1 + data_bits + (parity?1:0) + (cfg_stop2?2:1).
- Back-to-back frames: the START of the next frame begins on the clk after the final stop-bit end (zero-clk gap). busy stays 1 and frame_done pulses once.
- frame_done is asserted in the clk following the final stop-bit end, coincident with tx either re-entering START or idling.
- baud_tick while in IDLE has no effect.
- tx is registered and glitch-free.

## Test plan
- Reset / idle: hold rst_n=0 for 3 clks with tx_valid=1 -> tx=1, busy=0, fifo_level=0, tx_ready=0. After release: tx_ready=1 and no word is captured.
- 8N1 frame: baud_tick=1, OVERSAMPLE=16, write 0xA5 -> tx falls 2 clks after the handshake. Line is 0,1,0,1,0,0,1,0,1,1, each bit 16 clks; 160 clks total; one frame_done.
- 8E1 and 8O1 with 0xA5 (four ones) -> parity bit 0 for even, 1 for odd. Frame is 176 clks.
- 7O2 with tx_data=0x1D5 -> only 0x55 (7 bits) sent. Parity = 1, two stop bits, frame 176 clks. Changing cfg mid-frame leaves the frame unchanged.
- FIFO full / back-to-back: write 5 words while the first is transmitting -> tx_ready drops when fifo_level=4 and the source stalls. All 5 frames go out with zero idle gap; busy stays 1 throughout; 5 frame_done pulses.
- Reset mid-DATA and clamps: assert rst_n=0 during bit 3 -> tx=1 and FIFO empty on the next edge. cfg_data_bits=2 yields a 5-bit frame; cfg_data_bits=15 yields a 9-bit frame.
